// File: rtl/regfile_mp.sv
// Multi-port integer register file with two write ports, same-cycle write-to-read
// bypass and a per-register busy scoreboard for hazard detection.
module regfile_mp #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = $clog2(NREG),
    parameter int unsigned NRD  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                bset,
    input  logic [AW-1:0]       bset_a
);

    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [NREG-1:0] clr;
    logic            commit0;
    logic            commit1;

    // Register 0 is never a write target, so it stays at its reset value of zero
    assign commit0 = we0 && (wa0 != '0);
    assign commit1 = we1 && (wa1 != '0);

    // Scoreboard next state: committed writes clear, a newer issue (bset) wins
    always_comb begin
        clr = '0;
        if (commit0) clr[wa0] = 1'b1;
        if (commit1) clr[wa1] = 1'b1;
        busy_nxt = busy & ~clr;
        if (bset && (bset_a != '0)) busy_nxt[bset_a] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Port 1 is written last so it overrides port 0 on an address collision
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
            busy <= '0;
        end else begin
            if (commit0) rf[wa0] <= wd0;
            if (commit1) rf[wa1] <= wd1;
            busy <= busy_nxt;
        end
    end

    // Read ports: bypass priority mirrors write priority
    for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
        logic [AW-1:0] a;
        assign a = ra[i*AW +: AW];
        assign rd[i*XLEN +: XLEN] = (a == '0)                ? '0  :
                                    (commit1 && (wa1 == a)) ? wd1 :
                                    (commit0 && (wa0 == a)) ? wd0 :
                                                              rf[a];
        assign rbusy[i] = busy[a] && !clr[a];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, bypass, x0, dual-write, scoreboard, mid-run reset.
module tb_regfile_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NRD  = 2;

    logic                clk;
    logic                reset;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rbusy;
    logic                we0, we1, bset;
    logic [AW-1:0]       wa0, wa1, bset_a;
    logic [XLEN-1:0]     wd0, wd1;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD)) dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .bset(bset), .bset_a(bset_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; bset = 1'b0;
        wa0 = '0; wa1 = '0; bset_a = '0;
        wd0 = '0; wd1 = '0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
        #1;
    endtask

    function automatic logic [XLEN-1:0] rdp(input int p);
        return rd[p*XLEN +: XLEN];
    endfunction

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < int'(NREG); r++) begin
            set_ra(AW'(r), AW'(NREG - 1 - r));
            check({tag, "_rd0"}, 64'(rdp(0)), 64'h0);
            check({tag, "_rd1"}, 64'(rdp(1)), 64'h0);
            check({tag, "_busy"}, 64'(rbusy), 64'h0);
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        ra = '0;
        tick();
        reset = 1'b0;
        check_all_zero("reset");

        // single write with same-cycle bypass, then stored value
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h0000_01C8;
        set_ra(5'd5, 5'd0);
        check("wr_bypass", 64'(rdp(0)), 64'h0000_01C8);
        tick(); idle(); #1;
        check("wr_stored", 64'(rdp(0)), 64'h0000_01C8);

        // x0 stays zero
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
        set_ra(5'd0, 5'd0);
        check("x0_bypass", 64'(rdp(0)), 64'h0);
        tick(); idle(); #1;
        check("x0_stored", 64'(rdp(0)), 64'h0);

        // dual write to same address: port 1 wins
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAAAA_AAAA;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h5555_5555;
        set_ra(5'd3, 5'd3);
        check("conf_bypass0", 64'(rdp(0)), 64'h5555_5555);
        check("conf_bypass1", 64'(rdp(1)), 64'h5555_5555);
        tick(); idle(); #1;
        check("conf_stored", 64'(rdp(0)), 64'h5555_5555);

        // dual write to different addresses
        we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h1111_1111;
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h2222_2222;
        tick(); idle();
        set_ra(5'd1, 5'd2);
        check("dual_r1", 64'(rdp(0)), 64'h1111_1111);
        check("dual_r2", 64'(rdp(1)), 64'h2222_2222);
        set_ra(5'd3, 5'd5);
        check("dual_keep3", 64'(rdp(0)), 64'h5555_5555);
        check("dual_keep5", 64'(rdp(1)), 64'h0000_01C8);

        // scoreboard: set, visible next cycle, cleared by a write in its cycle
        bset = 1'b1; bset_a = 5'd7;
        set_ra(5'd0, 5'd7);
        check("bset_same_cyc", 64'(rbusy), 64'h0);
        tick(); idle(); #1;
        check("bset_next_cyc", 64'(rbusy), 64'h2);
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h0000_0077;
        #1;
        check("clr_same_busy", 64'(rbusy), 64'h0);
        check("clr_same_rd", 64'(rdp(1)), 64'h0000_0077);
        tick(); idle(); #1;
        check("clr_after", 64'(rbusy), 64'h0);

        // set and clear of same register on one edge: set wins
        bset = 1'b1; bset_a = 5'd7;
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h0000_0070;
        #1;
        check("setclr_same", 64'(rbusy), 64'h0);
        tick(); idle(); #1;
        check("setclr_busy", 64'(rbusy), 64'h2);
        check("setclr_data", 64'(rdp(1)), 64'h0000_0070);

        // bset of x0 is ignored
        bset = 1'b1; bset_a = 5'd0;
        tick(); idle();
        set_ra(5'd0, 5'd7);
        check("bset_x0", 64'(rbusy), 64'h2);

        // reset mid-operation with pending busy bits and an in-flight write
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h1234_5678;
        tick(); idle();
        bset = 1'b1; bset_a = 5'd4;
        tick(); idle();
        bset = 1'b1; bset_a = 5'd9;
        tick(); idle();
        set_ra(5'd4, 5'd9);
        check("pre_rst_busy", 64'(rbusy), 64'h3);
        check("pre_rst_r4", 64'(rdp(0)), 64'h1234_5678);
        reset = 1'b1;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'hDEAD_BEEF;
        #1;
        check("rst_bypass", 64'(rdp(1)), 64'hDEAD_BEEF);
        tick(); idle();
        reset = 1'b0;
        set_ra(5'd4, 5'd9);
        check("post_rst_r4", 64'(rdp(0)), 64'h0);
        check("post_rst_r9", 64'(rdp(1)), 64'h0);
        check_all_zero("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
